teclado_matriz_scan: RTL and testbench

// - Input-side counterpart of the LED matrix row scanner. It reads a 4x4 key matrix.
// - Drives the four columns one at a time and samples the four row lines.
// - Debounces the press and the release, then reports one key code with a single-cycle valid pulse.
// - Sits beside the matrix display driver on the same clk/CH0 domain.
//   Its key code feeds the display/selection logic.

---
 rtl/teclado_matriz_scan.sv | 169 ++++++++++++++++
 tb/tb_teclado_matriz_scan.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_matriz_scan.sv
// 4x4 key matrix scanner: drives one column low at a time, synchronizes the rows,
// debounces press and release, and reports a key code with a one-cycle valid pulse.
module teclado_matriz_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       CH0,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int unsigned TW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);
  localparam bit DEB_ONE = (DEBOUNCE_TICKS == 1);

  typedef enum logic [1:0] {
    S_SCAN      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_PRESSED   = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_deb_cnt;
  logic [3:0]      r_rs1;
  logic [3:0]      r_rs2;
  logic [1:0]      r_col_idx;
  logic [1:0]      r_row_idx;
  logic [3:0]      r_col;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;

  state_t          w_state_nxt;
  logic [DW-1:0]   w_deb_nxt;
  logic [DW-1:0]   w_deb_inc;
  logic [1:0]      w_col_idx_nxt;
  logic [1:0]      w_row_idx_nxt;
  logic [1:0]      w_row_lo;
  logic [3:0]      w_code_nxt;
  logic            w_valid_nxt;
  logic            w_held_nxt;
  logic            w_tick;
  logic            w_row_bit;
  logic            w_accept;
  logic            w_release;
  logic            w_advance;

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_row_bit = r_rs2[r_row_idx];

  // Lowest active (low) row index in the synchronized row vector.
  always_comb begin
    w_row_lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rs2[i]) w_row_lo = 2'(i);
    end
  end

  // Next-state and next-output logic; every decision is gated by the scan tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_deb_nxt     = r_deb_cnt;
    w_deb_inc     = (r_deb_cnt == DEB_LAST) ? r_deb_cnt : r_deb_cnt + DW'(1);
    w_col_idx_nxt = r_col_idx;
    w_row_idx_nxt = r_row_idx;
    w_code_nxt    = r_key_code;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_key_held;
    w_accept      = 1'b0;
    w_release     = 1'b0;
    w_advance     = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        S_SCAN: begin
          if (r_rs2 != 4'hF) begin
            w_row_idx_nxt = w_row_lo;
            w_deb_nxt     = DW'(1);
            if (DEB_ONE) w_accept = 1'b1;
            else         w_state_nxt = S_DEB_PRESS;
          end else begin
            w_advance = 1'b1;
          end
        end
        S_DEB_PRESS: begin
          if (!w_row_bit) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc == DEB_LAST) w_accept = 1'b1;
          end else begin
            w_state_nxt = S_SCAN;
            w_advance   = 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_row_bit) begin
            w_deb_nxt = DW'(1);
            if (DEB_ONE) w_release = 1'b1;
            else         w_state_nxt = S_DEB_REL;
          end
        end
        S_DEB_REL: begin
          if (w_row_bit) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc == DEB_LAST) w_release = 1'b1;
          end else begin
            w_state_nxt = S_PRESSED;
          end
        end
        default: w_state_nxt = S_SCAN;
      endcase
    end

    if (w_accept) begin
      w_state_nxt = S_PRESSED;
      w_code_nxt  = {w_row_idx_nxt, r_col_idx};
      w_valid_nxt = 1'b1;
      w_held_nxt  = 1'b1;
    end
    if (w_release) begin
      w_state_nxt = S_SCAN;
      w_held_nxt  = 1'b0;
      w_advance   = 1'b1;
    end
    if (w_advance) w_col_idx_nxt = r_col_idx + 2'd1;
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge CH0) begin
    if (!CH0) begin
      r_state     <= S_SCAN;
      r_tick_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_rs1       <= 4'hF;
      r_rs2       <= 4'hF;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_rs1       <= ROW;
      r_rs2       <= r_rs1;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_col       <= ~(4'b0001 << w_col_idx_nxt);
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  assign COL       = r_col;
  assign KEY_CODE  = r_key_code;
  assign KEY_VALID = r_key_valid;
  assign KEY_HELD  = r_key_held;

endmodule

// File: tb/tb_teclado_matriz_scan.sv
// Bench for teclado_matriz_scan: key-matrix model, tick-level reference model,
// table-driven key vectors, hand sequences for bounce/reset, and random presses.
module tb_teclado_matriz_scan;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       CH0 = 1'b0;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;
  logic [15:0] keys = 16'h0;

  int n_checks = 0;
  int n_errors = 0;
  int dut_pulses = 0;
  bit mon_en = 1'b0;

  teclado_matriz_scan #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk(clk), .CH0(CH0), .ROW(ROW), .COL(COL),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_HELD(KEY_HELD)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its column.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase name, tick phase, stable-tick count, column as integer.
  typedef enum int {M_IDLE, M_CONFIRM_PRESS, M_HOLD, M_CONFIRM_REL} mphase_t;
  mphase_t m_phase = M_IDLE;
  int m_cnt = 0, m_col = 0, m_stable = 0, m_r = 0, m_c = 0, m_pulses = 0;
  int m_code = 0;
  bit m_valid = 0, m_held = 0;
  logic [3:0] m_hist [2];

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge CH0) begin
    logic [3:0] rs;
    bit tick;
    if (!CH0) begin
      m_phase = M_IDLE; m_cnt = 0; m_col = 0; m_stable = 0;
      m_code = 0; m_valid = 0; m_held = 0;
      m_hist[0] = 4'hF; m_hist[1] = 4'hF;
    end else begin
      rs = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = ROW;
      tick = (m_cnt == DIV - 1);
      m_cnt = (m_cnt + 1) % DIV;
      m_valid = 0;
      if (tick) begin
        case (m_phase)
          M_IDLE:
            if (first_low(rs) >= 0) begin
              m_r = first_low(rs); m_c = m_col; m_stable = 1;
              m_phase = M_CONFIRM_PRESS;
            end else m_col = (m_col + 1) % 4;
          M_CONFIRM_PRESS:
            if (!rs[m_r]) m_stable++;
            else begin m_phase = M_IDLE; m_col = (m_col + 1) % 4; end
          M_HOLD:
            if (rs[m_r]) begin m_stable = 1; m_phase = M_CONFIRM_REL; end
          M_CONFIRM_REL:
            if (rs[m_r]) m_stable++;
            else m_phase = M_HOLD;
          default: m_phase = M_IDLE;
        endcase
        if (m_phase == M_CONFIRM_PRESS && m_stable >= DEB) begin
          m_phase = M_HOLD; m_code = m_r * 4 + m_c;
          m_valid = 1; m_held = 1; m_pulses++;
        end
        if (m_phase == M_CONFIRM_REL && m_stable >= DEB) begin
          m_phase = M_IDLE; m_held = 0; m_col = (m_col + 1) % 4;
        end
      end
    end
  end

  // Continuous comparison against the model plus the no-back-to-back-valid rule.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("col", 32'(COL), 32'(4'hF ^ (4'b1 << m_col)));
      chk("key_code", 32'(KEY_CODE), 32'(m_code));
      chk("key_valid", 32'(KEY_VALID), 32'(m_valid));
      chk("key_held", 32'(KEY_HELD), 32'(m_held));
      if (prev_valid) chk("valid_twice", 32'(KEY_VALID), 32'd0);
    end
    if (KEY_VALID === 1'b1) dut_pulses++;
    prev_valid = KEY_VALID;
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_held(input logic v, input int max, input string name);
    int i;
    for (i = 0; i < max && KEY_HELD !== v; i++) step(1);
    if (KEY_HELD !== v) chk(name, 32'(KEY_HELD), 32'(v));
  endtask

  task automatic wait_col(input logic [3:0] v, input int max, input string name);
    int i;
    for (i = 0; i < max && COL !== v; i++) step(1);
    if (COL !== v) chk(name, 32'(COL), 32'(v));
  endtask

  task automatic settle();
    keys = 16'h0;
    wait_held(1'b0, 300, "settle_timeout");
    step(40);
  endtask

  typedef struct {
    int ra; int ca; int rb; int cb; int hold;
    logic [3:0] exp_code; int exp_pulses;
  } vec_t;

  vec_t vecs [6];
  logic [3:0] col_seq [4];

  initial begin
    int p0, vt;
    vecs[0] = '{2, 1, -1, -1, 40, 4'd9, 1};
    vecs[1] = '{1, 0, 3, 0, 40, 4'd4, 1};
    vecs[2] = '{3, 3, -1, -1, 40, 4'd15, 1};
    vecs[3] = '{0, 2, 2, 2, 40, 4'd2, 1};
    vecs[4] = '{1, 1, -1, -1, 2, 4'd2, 0};
    vecs[5] = '{3, 0, -1, -1, 40, 4'd12, 1};
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    // Reset values.
    step(3);
    mon_en = 1'b1;
    chk("rst_col", 32'(COL), 32'(4'b1110));
    chk("rst_code", 32'(KEY_CODE), 32'd0);
    chk("rst_valid", 32'(KEY_VALID), 32'd0);
    chk("rst_held", 32'(KEY_HELD), 32'd0);
    CH0 = 1'b1;

    // Idle scan: each column held DIV cycles, first change DIV cycles after reset release.
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk("idle_col", 32'(COL), 32'(col_seq[(i / DIV) % 4]));
      chk("idle_valid", 32'(KEY_VALID), 32'd0);
    end

    // Table-driven key vectors.
    foreach (vecs[k]) begin
      settle();
      p0 = dut_pulses;
      keys[vecs[k].ra*4 + vecs[k].ca] = 1'b1;
      if (vecs[k].rb >= 0) keys[vecs[k].rb*4 + vecs[k].cb] = 1'b1;
      step(vecs[k].hold);
      if (vecs[k].exp_pulses == 1) begin
        chk("vec_frozen_col", 32'(COL), 32'(4'hF ^ (4'b1 << vecs[k].ca)));
        chk("vec_held", 32'(KEY_HELD), 32'd1);
      end
      keys = 16'h0;
      if (vecs[k].exp_pulses == 1) begin
        wait_held(1'b0, 100, "vec_release_timeout");
        chk("vec_resume_col", 32'(COL), 32'(4'hF ^ (4'b1 << ((vecs[k].ca + 1) % 4))));
      end
      step(20);
      chk("vec_pulses", 32'(dut_pulses - p0), 32'(vecs[k].exp_pulses));
      chk("vec_code", 32'(KEY_CODE), 32'(vecs[k].exp_code));
    end

    // Press bounce on r=0,c=3: seen on one tick only.
    settle();
    p0 = dut_pulses;
    wait_col(4'b0111, 40, "bounce_col_timeout");
    keys[3] = 1'b1;
    step(DIV);
    keys = 16'h0;
    step(6);
    chk("bounce_col", 32'(COL), 32'(4'b1110));
    chk("bounce_pulses", 32'(dut_pulses - p0), 32'd0);
    chk("bounce_held", 32'(KEY_HELD), 32'd0);

    // Release bounce on r=1,c=2: one high tick while held.
    settle();
    keys[6] = 1'b1;
    wait_held(1'b1, 100, "relb_press_timeout");
    step(6);
    p0 = dut_pulses;
    keys = 16'h0;
    step(DIV);
    keys[6] = 1'b1;
    vt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (KEY_HELD !== 1'b1) vt++;
    end
    chk("relb_held_drops", 32'(vt), 32'd0);
    chk("relb_pulses", 32'(dut_pulses - p0), 32'd0);
    keys = 16'h0;
    wait_held(1'b0, 100, "relb_release_timeout");

    // Reset during press debounce, then a fresh full debounce.
    settle();
    wait_col(4'b1110, 40, "rst_col_timeout");
    keys[0] = 1'b1;
    step(5);
    CH0 = 1'b0;
    step(1);
    chk("midrst_col", 32'(COL), 32'(4'b1110));
    chk("midrst_valid", 32'(KEY_VALID), 32'd0);
    chk("midrst_held", 32'(KEY_HELD), 32'd0);
    chk("midrst_code", 32'(KEY_CODE), 32'd0);
    step(2);
    CH0 = 1'b1;
    vt = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (KEY_VALID === 1'b1 && vt < 0) vt = i;
    end
    chk("midrst_valid_delay", 32'(vt), 32'(DEB * DIV));
    chk("midrst_code_after", 32'(KEY_CODE), 32'd0);

    // Random presses, one or two keys, varied hold and gap lengths.
    settle();
    for (int n = 0; n < 25; n++) begin
      keys = 16'h0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      step($urandom_range(1, 60));
      keys = 16'h0;
      step($urandom_range(0, 40));
    end
    settle();
    chk("rand_pulse_total", 32'(dut_pulses), 32'(m_pulses));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
